// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx : host-to-device PS/2 command transmitter
//
// Sends one command byte to a PS/2 device as an 11-bit frame:
// start(0), data[0..7] LSB first, odd parity, stop(1).
// The host requests to send by inhibiting the clock, then asserting the
// start bit and releasing the clock. After that, the device generates the
// bit clock and the host changes data after each falling edge.
// The host then samples the device ACK on the 11th falling edge.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   send_valid   request to send send_data
//   send_data    command byte
//   send_ready   high when a request can be accepted (IDLE, not in done cycle)
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   busy         high in any state other than IDLE
//   done         one-cycle pulse at the end of every transfer
//   ack_ok       device ACK seen (valid from done until next accept)
//   err_timeout  transfer aborted by timeout (valid from done until next accept)
//
// Optional feature macro: PS2_TX_RETRY_EN
//   When defined, a NACK or timeout restarts the transfer once from INHIBIT
//   with the latched byte; only the final attempt is reported.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_WAIT_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic             data_drv_q, data_drv_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             tmo_q, tmo_d;

`ifdef PS2_TX_RETRY_EN
    logic             retry_q, retry_d;
    logic [7:0]       byte_q, byte_d;
`endif

    // Line synchronizers; preset high so reset looks like idle lines.
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;
    logic fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    assign fall = clk_s3_q & ~clk_s2_q;

    // Line drivers decode directly from state so an asynchronous reset
    // releases both lines immediately.
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
    assign ps2_data_oe = (state_q == S_START) || ((state_q == S_SHIFT) && data_drv_q);
    assign busy        = (state_q != S_IDLE);
    // done is registered, so the pulse lands in the first IDLE cycle; keep
    // ready low there so a new accept never coincides with done.
    assign send_ready  = (state_q == S_IDLE) && !done_q;
    assign done        = done_q;
    assign ack_ok      = ack_q;
    assign err_timeout = tmo_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_drv_d = data_drv_q;
        done_d     = 1'b0;
        ack_d      = ack_q;
        tmo_d      = tmo_q;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
        byte_d     = byte_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (send_valid && send_ready) begin
                    state_d   = S_INHIBIT;
                    cnt_d     = '0;
                    shift_d   = {1'b1, ~^send_data, send_data};
                    bit_cnt_d = 4'd0;
                    ack_d     = 1'b0;
                    tmo_d     = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 1'b0;
                    byte_d    = send_data;
`endif
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                // START..WAIT_IDLE share the timeout counter; a falling
                // edge restarts it and takes priority over expiry.
                cnt_d = fall ? '0 : cnt_q + CNT_W'(1);

                if (!fall && (cnt_q == TMO_LAST)) begin
`ifdef PS2_TX_RETRY_EN
                    if (!retry_q) begin
                        state_d   = S_INHIBIT;
                        cnt_d     = '0;
                        shift_d   = {1'b1, ~^byte_q, byte_q};
                        bit_cnt_d = 4'd0;
                        ack_d     = 1'b0;
                        tmo_d     = 1'b0;
                        retry_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = S_IDLE;
                        tmo_d   = 1'b1;
                        ack_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    case (state_q)
                        S_START: begin
                            state_d    = S_SHIFT;
                            data_drv_d = 1'b1;
                        end

                        S_SHIFT: begin
                            if (fall) begin
                                data_drv_d = ~shift_q[0];
                                shift_d    = {1'b1, shift_q[9:1]};
                                bit_cnt_d  = bit_cnt_q + 4'd1;
                                // 10th edge presents the stop bit.
                                if (bit_cnt_q == 4'd9) begin
                                    state_d = S_WAIT_ACK;
                                end
                            end
                        end

                        S_WAIT_ACK: begin
                            if (fall) begin
                                ack_d   = ~data_s2_q;
                                state_d = S_WAIT_IDLE;
                            end
                        end

                        S_WAIT_IDLE: begin
                            if (clk_s2_q && data_s2_q) begin
`ifdef PS2_TX_RETRY_EN
                                if (!ack_q && !retry_q) begin
                                    state_d   = S_INHIBIT;
                                    cnt_d     = '0;
                                    shift_d   = {1'b1, ~^byte_q, byte_q};
                                    bit_cnt_d = 4'd0;
                                    ack_d     = 1'b0;
                                    tmo_d     = 1'b0;
                                    retry_d   = 1'b1;
                                end else
`endif
                                begin
                                    state_d = S_IDLE;
                                    done_d  = 1'b1;
                                end
                            end
                        end

                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            data_drv_q <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_drv_q <= data_drv_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_q <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            retry_q <= retry_d;
            byte_q  <= byte_d;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int H = 100;   // device half clock period in system clocks

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send_valid = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       send_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(5000),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .err_timeout(err_timeout)
    );

    always #10 clk = ~clk;

    initial begin
        #1800000;
        $display("FAIL global_time_limit observed=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic accept_byte(input logic [7:0] b, output bit ok);
        @(negedge clk);
        send_data  = b;
        send_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        send_valid = 1'b0;
    endtask

    task automatic dev_run(input int nclk, input bit do_ack,
                           output logic [9:0] cap, output bit got_req, output bit start_low);
        cap = '0;
        got_req = 1'b0;
        start_low = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (!ps2_clk_oe && ps2_data_oe) begin
                got_req = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got_req) begin
            start_low = !ps2_data_in;
            for (int k = 1; k <= nclk; k++) begin
                repeat (H) @(negedge clk);
                dev_clk = 1'b0;
                repeat (H) @(negedge clk);
                dev_clk = 1'b1;
                if (k <= 10) cap[k-1] = ps2_data_in;
                if (k == 10 && do_ack) dev_data = 1'b0;
                if (k == 11) dev_data = 1'b1;
            end
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe got=%b want=0", ps2_clk_oe); else pass_cnt++;
        total_cnt++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe got=%b want=0", ps2_data_oe); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
        total_cnt++; if (ack_ok !== 1'b0) $display("FAIL reset_ack got=%b want=0", ack_ok); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL reset_err got=%b want=0", err_timeout); else pass_cnt++;
        total_cnt++; if (send_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", send_ready); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (send_ready !== 1'b1) $display("FAIL post_reset_ready got=%b want=1", send_ready); else pass_cnt++;
    endtask

    task automatic test_send_ack();
        bit ok, got, st, seen;
        logic [9:0] cap;
        int n;
        accept_byte(8'hED, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL ed_accept got=%b want=1", ok); else pass_cnt++;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 6000) begin
            n++;
            @(negedge clk);
        end
        total_cnt++; if (n != 5000) $display("FAIL inhibit_len got=%0d want=5000", n); else pass_cnt++;
        total_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) $display("FAIL start_cycle got=%b want=11", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) $display("FAIL shift_entry got=%b want=01", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        dev_run(11, 1'b1, cap, got, st);
        total_cnt++; if (got !== 1'b1) $display("FAIL ed_request got=%b want=1", got); else pass_cnt++;
        total_cnt++; if (st !== 1'b1) $display("FAIL ed_start_bit got=%b want=1", st); else pass_cnt++;
        total_cnt++; if (cap !== 10'b11_1110_1101) $display("FAIL ed_frame got=%b want=1111101101", cap); else pass_cnt++;
        wait_done(seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL ed_done got=%b want=1", seen); else pass_cnt++;
        total_cnt++; if (ack_ok !== 1'b1) $display("FAIL ed_ack got=%b want=1", ack_ok); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL ed_err got=%b want=0", err_timeout); else pass_cnt++;
        total_cnt++; if (send_ready !== 1'b0) $display("FAIL ed_ready_in_done got=%b want=0", send_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL ed_done_width got=%b want=0", done); else pass_cnt++;
        total_cnt++; if (send_ready !== 1'b1) $display("FAIL ed_ready_after got=%b want=1", send_ready); else pass_cnt++;
    endtask

    task automatic test_nack();
        bit ok, got, st, seen;
        logic [9:0] cap;
        accept_byte(8'h00, ok);
        dev_run(11, 1'b0, cap, got, st);
        total_cnt++; if (cap !== 10'b11_0000_0000) $display("FAIL nack_frame got=%b want=1100000000", cap); else pass_cnt++;
        wait_done(seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL nack_done got=%b want=1", seen); else pass_cnt++;
        total_cnt++; if (ack_ok !== 1'b0) $display("FAIL nack_ack got=%b want=0", ack_ok); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL nack_err got=%b want=0", err_timeout); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        accept_byte(8'h3C, ok);
        for (int i = 0; i < 6000; i++) begin
            if (ps2_clk_oe && ps2_data_oe) break;
            @(negedge clk);
        end
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        total_cnt++; if (n != 2000) $display("FAIL timeout_len got=%0d want=2000", n); else pass_cnt++;
        total_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_lines got=%b want=00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b1) $display("FAIL timeout_err got=%b want=1", err_timeout); else pass_cnt++;
        total_cnt++; if (ack_ok !== 1'b0) $display("FAIL timeout_ack got=%b want=0", ack_ok); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (send_ready !== 1'b1) $display("FAIL timeout_ready got=%b want=1", send_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok, got, st, seen;
        logic [9:0] cap;
        int dones;
        accept_byte(8'h12, ok);
        dev_run(4, 1'b0, cap, got, st);
        // Fourth bit presented is data[3] of 0x12, a zero.
        total_cnt++; if (ps2_data_oe !== 1'b1) $display("FAIL mid_bit3 got=%b want=1", ps2_data_oe); else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL mid_reset_lines got=%b want=00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got=%b want=0", busy); else pass_cnt++;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
        end
        total_cnt++; if (dones != 0) $display("FAIL mid_reset_done got=%0d want=0", dones); else pass_cnt++;
        accept_byte(8'hF4, ok);
        dev_run(11, 1'b1, cap, got, st);
        total_cnt++; if (cap !== 10'b10_1111_0100) $display("FAIL f4_frame got=%b want=1011110100", cap); else pass_cnt++;
        wait_done(seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL f4_done got=%b want=1", seen); else pass_cnt++;
        total_cnt++; if (ack_ok !== 1'b1) $display("FAIL f4_ack got=%b want=1", ack_ok); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok, got, st, seen;
        logic [9:0] cap;
        @(negedge clk);
        send_data  = 8'hFF;
        send_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        send_data = 8'hAA;
        total_cnt++; if (ok !== 1'b1) $display("FAIL b2b_accept got=%b want=1", ok); else pass_cnt++;
        dev_run(11, 1'b1, cap, got, st);
        total_cnt++; if (cap !== 10'b11_1111_1111) $display("FAIL b2b_ff_frame got=%b want=1111111111", cap); else pass_cnt++;
        wait_done(seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL b2b_ff_done got=%b want=1", seen); else pass_cnt++;
        total_cnt++; if (send_ready !== 1'b0) $display("FAIL b2b_ready_in_done got=%b want=0", send_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (send_ready !== 1'b1) $display("FAIL b2b_ready_after got=%b want=1", send_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({busy, ps2_clk_oe} !== 2'b11) $display("FAIL b2b_aa_accept got=%b want=11", {busy, ps2_clk_oe}); else pass_cnt++;
        send_valid = 1'b0;
        dev_run(11, 1'b1, cap, got, st);
        total_cnt++; if (cap !== 10'b11_1010_1010) $display("FAIL b2b_aa_frame got=%b want=1110101010", cap); else pass_cnt++;
        wait_done(seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL b2b_aa_done got=%b want=1", seen); else pass_cnt++;
        total_cnt++; if (ack_ok !== 1'b1) $display("FAIL b2b_aa_ack got=%b want=1", ack_ok); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_send_ack();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
